key_scheduler: RTL

//  Arbitrates the single USB keycode (NIOS keycode PIO) between the four scene consumers: start, chooser, roam, battle.

---
 rtl/pokemon_pkg.sv | 19 +
 rtl/key_event_fifo.sv | 53 +++++
 rtl/key_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pokemon_pkg.sv
// Shared types and constants for the game's input path and scene sequencing.
package pokemon_pkg;

  typedef enum logic [1:0] {
    SCENE_START   = 2'd0,
    SCENE_CHOOSER = 2'd1,
    SCENE_ROAM    = 2'd2,
    SCENE_BATTLE  = 2'd3
  } scene_idx_e;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    KS_LOCK,
    KS_IDLE,
    KS_DISPATCH
  } ks_state_e;

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous keycode FIFO with flush; DEPTH must be a power of two so pointers wrap freely.
module key_event_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [7:0]              data_i,
  output logic [7:0]              data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A full FIFO still accepts a push when the same cycle pops.
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/key_scheduler.sv
// Routes keycode presses to the active scene with post-transition lockout.
// Optional auto-repeat of held keys is enabled by defining KEY_REPEAT_EN.
module key_scheduler
  import pokemon_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LOCK_FRAMES  = 8,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [7:0]                   keycode,
  input  logic                         frame_clk,
  input  logic [3:0]                   scene,
  output logic [7:0]                   evt_code,
  output logic [3:0]                   evt_valid,
  input  logic [3:0]                   evt_ready,
  output logic                         locked,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  ks_state_e  state_q, state_d;
  logic [7:0] keycode_q, lock_cnt_q, lock_cnt_d, evt_code_q, evt_code_d;
  logic [3:0] scene_q, evt_valid_q, evt_valid_d;
  logic [2:0] frame_sync_q;
  logic       overflow_q, overflow_d;
  logic       frame_edge, scene_chg, press, rep_push, push_req, transfer;
  logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  assign frame_edge = frame_sync_q[1] & ~frame_sync_q[2];
  assign scene_chg  = (scene != scene_q);
  assign press      = (keycode != KEY_NONE) && (keycode != keycode_q);
  assign push_req   = press | rep_push;
  assign transfer   = |(evt_valid_q & evt_ready);
  assign fifo_pop   = (state_q == KS_DISPATCH) & transfer & ~scene_chg;
  assign fifo_push  = push_req & ~scene_chg & (state_q != KS_LOCK);
  assign fifo_flush = scene_chg | (state_q == KS_LOCK);

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (keycode),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] RepDelay = 8'(REPEAT_DELAY);
  localparam logic [7:0] RepRate  = 8'(REPEAT_RATE);

  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic       rep_first_q, rep_first_d;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    if (scene_chg || state_q == KS_LOCK || keycode != keycode_q || keycode == KEY_NONE) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (frame_edge) begin
      if (rep_cnt_q + 8'd1 == (rep_first_q ? RepRate : RepDelay)) begin
        rep_push    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic [15:0] rep_cfg_unused;
  assign rep_cfg_unused = 16'(REPEAT_DELAY + REPEAT_RATE);
  assign rep_push       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    evt_valid_d = '0;
    evt_code_d  = evt_code_q;
    overflow_d  = overflow_q;
    if (scene_chg) begin
      state_d    = KS_LOCK;
      lock_cnt_d = 8'(LOCK_FRAMES);
    end else begin
      unique case (state_q)
        KS_LOCK: begin
          if (lock_cnt_q == 8'd0) begin
            state_d = KS_IDLE;
          end else if (frame_edge) begin
            lock_cnt_d = lock_cnt_q - 8'd1;
            if (lock_cnt_q == 8'd1) state_d = KS_IDLE;
          end
        end
        KS_IDLE: begin
          if (push_req) state_d = KS_DISPATCH;
        end
        KS_DISPATCH: begin
          if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
          if (fifo_pop && fifo_count == CntW'(1) && !push_req) begin
            state_d = KS_IDLE;
          end else if (!transfer && !fifo_empty && $onehot(scene)) begin
            // Re-offered every cycle until accepted; the head only moves on a pop.
            evt_valid_d = scene;
            evt_code_d  = fifo_head;
          end
        end
        default: state_d = KS_LOCK;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= KS_LOCK;
      lock_cnt_q   <= 8'(LOCK_FRAMES);
      keycode_q    <= KEY_NONE;
      scene_q      <= '0;
      frame_sync_q <= '0;
      evt_valid_q  <= '0;
      evt_code_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      keycode_q    <= keycode;
      scene_q      <= scene;
      frame_sync_q <= {frame_sync_q[1:0], frame_clk};
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign locked    = (state_q == KS_LOCK);
  assign overflow  = overflow_q;

endmodule
